// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage. Serves byte/half/word loads and stores
// after a programmable number of wait states and stalls the pipeline until the response.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  ByteSel,
   input  logic        SignExt,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Ready,
   output logic        Stall,
   output logic        Misaligned
);

   localparam int ADDR_W = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t              state, next_state;
   logic [3:0]          wait_cnt;
   logic                req;
   logic [ADDR_W+1:0]   cap_addr;
   logic [31:0]         cap_wdata;
   logic [1:0]          cap_bsel;
   logic                cap_sext;
   logic                cap_write;
   logic [31:0]         held_data;
   logic [31:0]         cur_word;
   logic [31:0]         merged_word;
   logic [31:0]         load_value;
   logic [31:0]         resp_data;
   logic [7:0]          lane_byte;
   logic [15:0]         lane_half;
   logic                fault;
   logic                unused_addr_bits;

   logic [31:0] mem [DEPTH_WORDS];

   // Address bits above the array span are intentionally dropped so accesses wrap.
   assign unused_addr_bits = ^Address[31:ADDR_W+2];

   assign req      = MemRead | MemWrite;
   assign cur_word = mem[cap_addr[ADDR_W+1:2]];

   // State register with synchronous reset; a reset in any state aborts the request.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Rst) state <= S_IDLE;
      else     state <= next_state;
   end

   // Next-state decode: IDLE -> (WAIT ->) RESP -> IDLE.
   // NOTE: next_state gets a default before the case so no path can infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: if (req) next_state = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
         S_WAIT: if (wait_cnt == 4'd0) next_state = S_RESP;
         S_RESP: next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Wait-state counter: loaded on acceptance, counts down to zero in WAIT.
   always_ff @(posedge Clk) begin
      if (Rst)                              wait_cnt <= 4'd0;
      else if (state == S_IDLE && req)      wait_cnt <= WAIT_LOAD;
      else if (state == S_WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
   end

   // Request capture on acceptance; MemWrite wins over MemRead.
   always_ff @(posedge Clk) begin
      if (!Rst && state == S_IDLE && req) begin
         cap_addr  <= Address[ADDR_W+1:0];
         cap_wdata <= WriteData;
         cap_bsel  <= ByteSel;
         cap_sext  <= SignExt;
         cap_write <= MemWrite;
      end
   end

   // Alignment check, lane extraction, load extension and store merge.
   always_comb begin
      fault       = 1'b0;
      lane_byte   = 8'(cur_word >> {cap_addr[1:0], 3'b000});
      lane_half   = 16'(cur_word >> {cap_addr[1], 4'b0000});
      load_value  = cur_word;
      merged_word = cur_word;
      case (cap_bsel)
         2'b01: begin
            fault       = cap_addr[0];
            load_value  = cap_sext ? {{16{lane_half[15]}}, lane_half} : {16'h0, lane_half};
            merged_word[{cap_addr[1], 4'b0000} +: 16] = cap_wdata[15:0];
         end
         2'b10: begin
            load_value  = cap_sext ? {{24{lane_byte[7]}}, lane_byte} : {24'h0, lane_byte};
            merged_word[{cap_addr[1:0], 3'b000} +: 8] = cap_wdata[7:0];
         end
         default: begin
            fault       = |cap_addr[1:0];
            merged_word = cap_wdata;
         end
      endcase
      resp_data = (fault || cap_write) ? 32'h0 : load_value;
   end

   // Store commit at the end of a completed RESP cycle; a reset in RESP cancels it.
   // NOTE: the storage array has no reset; contents survive Rst and it maps onto RAM.
   always_ff @(posedge Clk) begin
      if (!Rst && state == S_RESP && cap_write && !fault)
         mem[cap_addr[ADDR_W+1:2]] <= merged_word;
   end

   // Hold register keeps the last response data visible outside RESP.
   always_ff @(posedge Clk) begin
      if (Rst)                  held_data <= 32'h0;
      else if (state == S_RESP) held_data <= resp_data;
   end

   assign ReadData   = (state == S_RESP) ? resp_data : held_data;
   assign Ready      = (state == S_RESP);
   assign Misaligned = (state == S_RESP) && fault;
   assign Stall      = ((state == S_IDLE) && req) || (state == S_WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench: one responder with two wait states and one with none.
module tb_data_mem_responder;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        mem_read, mem_write, sign_ext;
   logic [1:0]  byte_sel;
   logic [31:0] address, write_data;
   logic        use_ws0;

   logic [31:0] rdata2, rdata0;
   logic        ready2, ready0, stall2, stall0, mis2, mis0;
   logic [31:0] rdata;
   logic        ready, stall, mis;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut_ws2 (
      .Clk(Clk), .Rst(Rst),
      .MemRead(mem_read & ~use_ws0), .MemWrite(mem_write & ~use_ws0),
      .ByteSel(byte_sel), .SignExt(sign_ext), .Address(address), .WriteData(write_data),
      .ReadData(rdata2), .Ready(ready2), .Stall(stall2), .Misaligned(mis2)
   );

   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_ws0 (
      .Clk(Clk), .Rst(Rst),
      .MemRead(mem_read & use_ws0), .MemWrite(mem_write & use_ws0),
      .ByteSel(byte_sel), .SignExt(sign_ext), .Address(address), .WriteData(write_data),
      .ReadData(rdata0), .Ready(ready0), .Stall(stall0), .Misaligned(mis0)
   );

   assign rdata = use_ws0 ? rdata0 : rdata2;
   assign ready = use_ws0 ? ready0 : ready2;
   assign stall = use_ws0 ? stall0 : stall2;
   assign mis   = use_ws0 ? mis0   : mis2;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One access from the pipeline side; entered and left just after a rising edge.
   task automatic access(input string tag, input bit wr, input bit rd, input logic [1:0] bs,
                         input bit se, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input bit exp_mis);
      int  lat, stalls;
      bit  got;
      logic [31:0] rd_v;
      logic mis_v, stall_v;
      int  exp_lat;
      exp_lat = use_ws0 ? 1 : 3;
      mem_write = wr; mem_read = rd; byte_sel = bs; sign_ext = se;
      address = addr; write_data = wd;
      got = 0; lat = 0; stalls = 0; rd_v = '0; mis_v = 1'b0; stall_v = 1'b0;
      for (int c = 0; c < 16 && !got; c++) begin
         @(negedge Clk);
         if (ready) begin
            got = 1; lat = c; rd_v = rdata; mis_v = mis; stall_v = stall;
         end else if (stall) stalls++;
      end
      mem_write = 1'b0; mem_read = 1'b0;
      check({tag, "_ready_seen"}, 32'(got), 32'd1);
      if (got) begin
         check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
         check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
         check({tag, "_stall_in_resp"}, 32'(stall_v), 32'd0);
         check({tag, "_rdata"}, rd_v, exp_rd);
         check({tag, "_misaligned"}, 32'(mis_v), 32'(exp_mis));
      end
      @(posedge Clk); #1;
   endtask

   initial begin
      int pulses;
      use_ws0 = 1'b0; mem_read = 1'b0; mem_write = 1'b0; byte_sel = 2'b00;
      sign_ext = 1'b0; address = '0; write_data = '0;
      Rst = 1'b1;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_mis",   32'(mis),   32'd0);
      check("rst_rdata", rdata, 32'h0);
      @(posedge Clk); #1;
      Rst = 1'b0;
      @(posedge Clk); #1;

      // Word store/load, then signed and unsigned byte loads.
      access("sw_10",  1, 0, 2'b00, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0);
      access("lw_10",  0, 1, 2'b00, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0);
      access("lb_13",  0, 1, 2'b10, 1, 32'h13, 32'h0,        32'hFFFFFFDE, 0);
      access("lbu_12", 0, 1, 2'b10, 0, 32'h12, 32'h0,        32'h000000AD, 0);

      // Narrow stores merge into the addressed lanes only.
      access("sh_12",  1, 0, 2'b01, 0, 32'h12, 32'hFFFF1234, 32'h0,        0);
      access("sb_10",  1, 0, 2'b10, 0, 32'h10, 32'hABCDEF56, 32'h0,        0);
      access("lw_10m", 0, 1, 2'b00, 0, 32'h10, 32'h0,        32'h1234BE56, 0);
      @(negedge Clk);
      check("rdata_hold", rdata, 32'h1234BE56);
      @(posedge Clk); #1;
      access("lh_12",  0, 1, 2'b01, 1, 32'h12, 32'h0,        32'h00001234, 0);
      access("lh_10",  0, 1, 2'b01, 1, 32'h10, 32'h0,        32'hFFFFBE56, 0);
      access("lw_bs3", 0, 1, 2'b11, 0, 32'h10, 32'h0,        32'h1234BE56, 0);

      // Alignment faults: no data, no write.
      access("lw_11",  0, 1, 2'b00, 0, 32'h11, 32'h0,        32'h0,        1);
      access("sh_13",  1, 0, 2'b01, 0, 32'h13, 32'h00009999, 32'h0,        1);
      access("lw_10f", 0, 1, 2'b00, 0, 32'h10, 32'h0,        32'h1234BE56, 0);

      // Reset during WAIT aborts a store.
      access("sw_20",  1, 0, 2'b00, 0, 32'h20, 32'h11223344, 32'h0,        0);
      mem_write = 1'b1; byte_sel = 2'b00; address = 32'h20; write_data = 32'hAAAAAAAA;
      @(posedge Clk); #1;
      Rst = 1'b1;
      @(negedge Clk);
      check("abort_ready_wait", 32'(ready), 32'd0);
      @(posedge Clk); #1;
      Rst = 1'b0; mem_write = 1'b0;
      @(negedge Clk);
      check("abort_stall_after", 32'(stall), 32'd0);
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
         if (ready) pulses++;
         @(negedge Clk);
      end
      check("abort_no_ready", 32'(pulses), 32'd0);
      @(posedge Clk); #1;
      access("lw_20",  0, 1, 2'b00, 0, 32'h20, 32'h0,        32'h11223344, 0);

      // Zero wait states, address wrap and write priority.
      use_ws0 = 1'b1;
      access("ws0_sw_1010", 1, 0, 2'b00, 0, 32'h1010, 32'hCAFEF00D, 32'h0,        0);
      access("ws0_lw_10",   0, 1, 2'b00, 0, 32'h0010, 32'h0,        32'hCAFEF00D, 0);
      access("ws0_rw_14",   1, 1, 2'b00, 0, 32'h0014, 32'h0BADC0DE, 32'h0,        0);
      access("ws0_lw_14",   0, 1, 2'b00, 0, 32'h0014, 32'h0,        32'h0BADC0DE, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
